// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter (package mem_arb_pkg).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    // Address field is sized for the widest supported port (ADDR_W up to 32).
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: strobes, write replication, read alignment, misalignment detect.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_out,
    output logic        misaligned
);

    logic [31:0] shifted;

    assign shifted = rdata_word >> {addr_lo, 3'b000};

    always_comb begin
        be         = 4'b0000;
        wdata_rep  = 32'h0;
        rdata_out  = 32'h0;
        misaligned = 1'b0;
        case (size)
            SIZE_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_out = shifted & 32'h0000_00FF;
            end
            SIZE_H: begin
                if (addr_lo[0]) begin
                    misaligned = 1'b1;
                end else begin
                    be = 4'b0011 << addr_lo;
                end
                wdata_rep = {2{wdata[15:0]}};
                rdata_out = shifted & 32'h0000_FFFF;
            end
            SIZE_W: begin
                if (addr_lo != 2'b00) begin
                    misaligned = 1'b1;
                end else begin
                    be = 4'b1111;
                end
                wdata_rep = wdata;
                rdata_out = shifted;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between the core and the debug loader.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed core-first priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [1:0]        core_size,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_err,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [1:0]        dbg_size,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t      state, state_next;
    req_t        req_q;
    logic        owner_q;
    logic        err_q;
    logic [2:0]  cnt_q;

    req_t        core_r, dbg_r, win_r, al_r;
    logic        winner;
    logic        grant;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_mis;
    logic [31:0] resp_data;

    always_comb begin
        core_r                    = '0;
        core_r.we                 = core_we;
        core_r.addr[ADDR_W-1:0]   = core_addr;
        core_r.size               = core_size;
        core_r.wdata              = core_wdata;
        dbg_r                     = '0;
        dbg_r.we                  = dbg_we;
        dbg_r.addr[ADDR_W-1:0]    = dbg_addr;
        dbg_r.size                = dbg_size;
        dbg_r.wdata               = dbg_wdata;
    end

`ifdef MEM_ARB_RR_EN
    logic last_q;

    // On a tie the port that was not served last wins; reset leaves "debug last".
    always_comb begin
        if (core_req && dbg_req) begin
            winner = (last_q == OWN_CORE) ? OWN_DBG : OWN_CORE;
        end else begin
            winner = core_req ? OWN_CORE : OWN_DBG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= OWN_DBG;
        end else if (grant) begin
            last_q <= winner;
        end
    end
`else
    always_comb begin
        winner = core_req ? OWN_CORE : OWN_DBG;
    end
`endif

    assign grant    = (state == S_IDLE) && (core_req || dbg_req);
    assign core_gnt = grant && (winner == OWN_CORE);
    assign dbg_gnt  = grant && (winner == OWN_DBG);
    assign win_r    = (winner == OWN_CORE) ? core_r : dbg_r;

    // One lane aligner serves both phases: the incoming request while idle
    // (error detection) and the latched request once the access is in flight.
    assign al_r = (state == S_IDLE) ? win_r : req_q;

    mem_lane_align u_align (
        .size       (al_r.size),
        .addr_lo    (al_r.addr[1:0]),
        .wdata      (al_r.wdata),
        .rdata_word (mem_rdata),
        .be         (al_be),
        .wdata_rep  (al_wdata),
        .rdata_out  (al_rdata),
        .misaligned (al_mis)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    state_next = al_mis ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_next = (LATENCY > 1) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            req_q   <= '0;
            owner_q <= OWN_CORE;
            err_q   <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state <= state_next;
            if (grant) begin
                req_q   <= win_r;
                owner_q <= winner;
                err_q   <= al_mis;
            end
            if (state == S_ACCESS) begin
                cnt_q <= 3'(LATENCY - 1);
            end else if (state == S_WAIT) begin
                cnt_q <= cnt_q - 3'd1;
            end
        end
    end

    assign mem_en    = (state == S_ACCESS);
    assign mem_we    = mem_en && req_q.we;
    assign mem_be    = mem_en ? al_be : 4'b0000;
    assign mem_addr  = mem_en ? {req_q.addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = mem_en ? al_wdata : '0;

    // Read data is only meaningful for completed loads; stores and rejects return zero.
    assign resp_data = ((state == S_RESP) && !err_q && !req_q.we) ? al_rdata : 32'h0;

    assign core_rvalid = (state == S_RESP) && (owner_q == OWN_CORE);
    assign dbg_rvalid  = (state == S_RESP) && (owner_q == OWN_DBG);
    assign core_err    = core_rvalid && err_q;
    assign dbg_err     = dbg_rvalid && err_q;
    assign core_rdata  = core_rvalid ? resp_data : 32'h0;
    assign dbg_rdata   = dbg_rvalid ? resp_data : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: LATENCY=1 and LATENCY=3 instances share stimulus, each with its own memory model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        core_req, core_we, dbg_req, dbg_we;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic [1:0]  core_size, dbg_size;

    logic        core_gnt_1, core_rvalid_1, core_err_1, dbg_gnt_1, dbg_rvalid_1, dbg_err_1, mem_en_1, mem_we_1;
    logic [3:0]  mem_be_1;
    logic [31:0] core_rdata_1, dbg_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
    logic        core_gnt_3, core_rvalid_3, core_err_3, dbg_gnt_3, dbg_rvalid_3, dbg_err_3, mem_en_3, mem_we_3;
    logic [3:0]  mem_be_3;
    logic [31:0] core_rdata_3, dbg_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_size(core_size),
        .core_wdata(core_wdata), .core_gnt(core_gnt_1), .core_rvalid(core_rvalid_1),
        .core_rdata(core_rdata_1), .core_err(core_err_1),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_size(dbg_size),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt_1), .dbg_rvalid(dbg_rvalid_1),
        .dbg_rdata(dbg_rdata_1), .dbg_err(dbg_err_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_be(mem_be_1), .mem_addr(mem_addr_1),
        .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_size(core_size),
        .core_wdata(core_wdata), .core_gnt(core_gnt_3), .core_rvalid(core_rvalid_3),
        .core_rdata(core_rdata_3), .core_err(core_err_3),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_size(dbg_size),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt_3), .dbg_rvalid(dbg_rvalid_3),
        .dbg_rdata(dbg_rdata_3), .dbg_err(dbg_err_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_be(mem_be_3), .mem_addr(mem_addr_3),
        .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3)
    );

    // Memory models: byte-masked writes, reads delivered through a delay line.
    logic        pre_we = 1'b0;
    logic [6:0]  pre_idx;
    logic [31:0] pre_val;
    logic [31:0] mem [0:1][0:127];
    logic [31:0] pipe [0:1][0:3];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic        en, we;
            logic [3:0]  be;
            logic [6:0]  idx;
            logic [31:0] wd;
            en  = (k == 0) ? mem_en_1 : mem_en_3;
            we  = (k == 0) ? mem_we_1 : mem_we_3;
            be  = (k == 0) ? mem_be_1 : mem_be_3;
            idx = (k == 0) ? mem_addr_1[8:2] : mem_addr_3[8:2];
            wd  = (k == 0) ? mem_wdata_1 : mem_wdata_3;
            if (pre_we) mem[k][pre_idx] <= pre_val;
            if (en && we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[k][idx][8*b +: 8] <= wd[8*b +: 8];
                end
            end
            pipe[k][0] <= (en && !we) ? mem[k][idx] : 32'hA5A5_A5A5;
            for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
        end
    end

    assign mem_rdata_1 = pipe[0][0];
    assign mem_rdata_3 = pipe[1][2];

    int tests = 0;
    int fails = 0;
    int sel   = 0;

    int          en_cyc, rv_cyc;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic        obs_we, obs_err;

    typedef struct {
        logic        pre;
        logic [31:0] pre_val;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic anyOut(input int k);
        if (k == 0)
            return |{core_gnt_1, core_rvalid_1, core_err_1, dbg_gnt_1, dbg_rvalid_1, dbg_err_1,
                     mem_en_1, mem_we_1, mem_be_1, mem_addr_1, mem_wdata_1, core_rdata_1, dbg_rdata_1};
        return |{core_gnt_3, core_rvalid_3, core_err_3, dbg_gnt_3, dbg_rvalid_3, dbg_err_3,
                 mem_en_3, mem_we_3, mem_be_3, mem_addr_3, mem_wdata_3, core_rdata_3, dbg_rdata_3};
    endfunction

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        pre_idx = addr[8:2];
        pre_val = val;
        pre_we  = 1'b1;
        @(negedge clk);
        pre_we  = 1'b0;
    endtask

    // Issues one access on a port of the selected instance and records what the memory side and requester saw.
    task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                                 input logic [1:0] size, input logic [31:0] wdata, input string tag);
        logic g, og, rv;
        if (port == OWN_CORE) begin
            core_req = 1'b1; core_we = we; core_addr = addr; core_size = size; core_wdata = wdata;
        end else begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_size = size; dbg_wdata = wdata;
        end
        #1;
        g  = (port == OWN_CORE) ? ((sel == 0) ? core_gnt_1 : core_gnt_3) : ((sel == 0) ? dbg_gnt_1 : dbg_gnt_3);
        og = (port == OWN_CORE) ? ((sel == 0) ? dbg_gnt_1 : dbg_gnt_3) : ((sel == 0) ? core_gnt_1 : core_gnt_3);
        checkOutput({tag, "_gnt"}, {31'b0, g}, 32'd1);
        checkOutput({tag, "_other_gnt"}, {31'b0, og}, 32'd0);
        en_cyc = -1; rv_cyc = -1;
        obs_be = '0; obs_addr = '0; obs_wdata = '0; obs_rdata = '0; obs_we = 1'b0; obs_err = 1'b0;
        for (int c = 1; c <= 10 && rv_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                core_req = 1'b0;
                dbg_req  = 1'b0;
            end
            #1;
            if ((sel == 0) ? mem_en_1 : mem_en_3) begin
                en_cyc    = c;
                obs_be    = (sel == 0) ? mem_be_1 : mem_be_3;
                obs_addr  = (sel == 0) ? mem_addr_1 : mem_addr_3;
                obs_wdata = (sel == 0) ? mem_wdata_1 : mem_wdata_3;
                obs_we    = (sel == 0) ? mem_we_1 : mem_we_3;
            end
            rv = (port == OWN_CORE) ? ((sel == 0) ? core_rvalid_1 : core_rvalid_3)
                                    : ((sel == 0) ? dbg_rvalid_1 : dbg_rvalid_3);
            if (rv) begin
                rv_cyc    = c;
                obs_rdata = (port == OWN_CORE) ? ((sel == 0) ? core_rdata_1 : core_rdata_3)
                                               : ((sel == 0) ? dbg_rdata_1 : dbg_rdata_3);
                obs_err   = (port == OWN_CORE) ? ((sel == 0) ? core_err_1 : core_err_3)
                                               : ((sel == 0) ? dbg_err_1 : dbg_err_3);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int          order [3];
        int          n, cg, crv, drv, nrv;
        logic [31:0] drd, crd;
        logic        exp_order [3];

        reset = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_size = 0; core_wdata = 0;
        dbg_req  = 0; dbg_we  = 0; dbg_addr  = 0; dbg_size  = 0; dbg_wdata  = 0;

        vecs[0]  = '{1'b1, 32'h1122_3344, 1'b0, 32'h100, SIZE_W, 32'h0,         4'b1111, 32'h0,         32'h1122_3344, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,         1'b1, 32'h103, SIZE_B, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h0,         1'b0, 32'h103, SIZE_B, 32'h0,         4'b1000, 32'h0,         32'h0000_00AB, 1'b0};
        vecs[3]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 32'h102, SIZE_H, 32'h0,         4'b1100, 32'h0,         32'h0000_DEAD, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,         1'b0, 32'h102, SIZE_W, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[5]  = '{1'b0, 32'h0,         1'b1, 32'h101, SIZE_H, 32'h0000_5555, 4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[6]  = '{1'b0, 32'h0,         1'b0, 32'h100, 2'b11,  32'h0,         4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[7]  = '{1'b0, 32'h0,         1'b0, 32'h100, SIZE_H, 32'h0,         4'b0011, 32'h0,         32'h0000_BEEF, 1'b0};
        vecs[8]  = '{1'b1, 32'h0,         1'b1, 32'h106, SIZE_H, 32'hFFFF_1234, 4'b1100, 32'h1234_1234, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 32'h0,         1'b0, 32'h104, SIZE_W, 32'h0,         4'b1111, 32'h0,         32'h1234_0000, 1'b0};
        vecs[10] = '{1'b1, 32'hCAFE_F00D, 1'b0, 32'h10D, SIZE_B, 32'h0,         4'b0010, 32'h0,         32'h0000_00F0, 1'b0};
        vecs[11] = '{1'b0, 32'h0,         1'b1, 32'h108, SIZE_B, 32'h1234_565A, 4'b0001, 32'h5A5A_5A5A, 32'h0,         1'b0};

        @(negedge clk);
        doReset();
        checkOutput("reset_outputs_lat1", {31'b0, anyOut(0)}, 32'd0);
        checkOutput("reset_outputs_lat3", {31'b0, anyOut(1)}, 32'd0);

        // Table-driven core accesses on the LATENCY=1 instance.
        sel = 0;
        for (int i = 0; i < 12; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            if (vecs[i].pre) preload(vecs[i].addr, vecs[i].pre_val);
            applyStimulus(OWN_CORE, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata, t);
            if (!vecs[i].exp_err) begin
                checkOutput({t, "_en_cycle"}, 32'(en_cyc), 32'd1);
                checkOutput({t, "_be"}, {28'b0, obs_be}, {28'b0, vecs[i].exp_be});
                checkOutput({t, "_addr"}, obs_addr, {vecs[i].addr[31:2], 2'b00});
                checkOutput({t, "_we"}, {31'b0, obs_we}, {31'b0, vecs[i].we});
                if (vecs[i].we) checkOutput({t, "_wdata"}, obs_wdata, vecs[i].exp_wdata);
                checkOutput({t, "_rvalid_cycle"}, 32'(rv_cyc), 32'd2);
            end else begin
                checkOutput({t, "_no_mem_en"}, 32'(en_cyc), 32'hFFFF_FFFF);
                checkOutput({t, "_rvalid_cycle"}, 32'(rv_cyc), 32'd1);
            end
            checkOutput({t, "_rdata"}, obs_rdata, vecs[i].exp_rdata);
            checkOutput({t, "_err"}, {31'b0, obs_err}, {31'b0, vecs[i].exp_err});
        end

        // Both ports request continuously for three grants.
        doReset();
`ifdef MEM_ARB_RR_EN
        exp_order = '{OWN_CORE, OWN_DBG, OWN_CORE};
`else
        exp_order = '{OWN_CORE, OWN_CORE, OWN_CORE};
`endif
        n = 0;
        core_req = 1; core_we = 0; core_addr = 32'h100; core_size = SIZE_W;
        dbg_req  = 1; dbg_we  = 0; dbg_addr  = 32'h104; dbg_size  = SIZE_W;
        for (int c = 0; c < 30 && n < 3; c++) begin
            #1;
            if (core_gnt_1)     begin order[n] = 0; n++; end
            else if (dbg_gnt_1) begin order[n] = 1; n++; end
            if (n < 3) @(negedge clk);
        end
        @(negedge clk);
        core_req = 0; dbg_req = 0;
        repeat (4) @(negedge clk);
        checkOutput("arb_grant_count", 32'(n), 32'd3);
        for (int i = 0; i < 3 && i < n; i++)
            checkOutput($sformatf("arb_order%0d", i), 32'(order[i]), {31'b0, exp_order[i]});

        // LATENCY=3: debug read, core request raised mid-access.
        doReset();
        sel = 1;
        preload(32'h110, 32'h8765_4321);
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h110; dbg_size = SIZE_W;
        #1;
        checkOutput("lat3_dbg_gnt", {31'b0, dbg_gnt_3}, 32'd1);
        drv = -1; cg = -1; crv = -1; drd = '0; crd = '0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) dbg_req = 0;
            if (c == 2) begin core_req = 1; core_we = 0; core_addr = 32'h111; core_size = SIZE_B; end
            if (cg >= 0 && c == cg + 1) core_req = 0;
            #1;
            if (dbg_rvalid_3) begin drv = c; drd = dbg_rdata_3; end
            if (core_gnt_3 && cg < 0) cg = c;
            if (core_rvalid_3) begin crv = c; crd = core_rdata_3; end
        end
        core_req = 0;
        checkOutput("lat3_dbg_rvalid_cycle", 32'(drv), 32'd4);
        checkOutput("lat3_dbg_rdata", drd, 32'h8765_4321);
        checkOutput("lat3_core_gnt_cycle", 32'(cg), 32'd5);
        checkOutput("lat3_core_rvalid_cycle", 32'(crv), 32'd9);
        checkOutput("lat3_core_rdata", crd, 32'h0000_0043);

        // Reset pulsed while the access sits in WAIT.
        @(negedge clk);
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h110; dbg_size = SIZE_W;
        #1;
        checkOutput("rst_dbg_gnt", {31'b0, dbg_gnt_3}, 32'd1);
        nrv = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) dbg_req = 0;
            if (c == 2) reset = 1;
            #1;
            if (c == 1) checkOutput("rst_mem_en_before", {31'b0, mem_en_3}, 32'd1);
            if (c == 3) begin
                checkOutput("rst_outputs_zero", {31'b0, anyOut(1)}, 32'd0);
                reset = 0;
            end
            if (dbg_rvalid_3) nrv++;
        end
        checkOutput("rst_no_rvalid", 32'(nrv), 32'd0);
        applyStimulus(OWN_DBG, 1'b0, 32'h110, SIZE_W, 32'h0, "post_rst");
        checkOutput("post_rst_en_cycle", 32'(en_cyc), 32'd1);
        checkOutput("post_rst_rvalid_cycle", 32'(rv_cyc), 32'd4);
        checkOutput("post_rst_rdata", obs_rdata, 32'h8765_4321);
        checkOutput("post_rst_err", {31'b0, obs_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
